uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmitter, the counterpart of the team's UART receiver. It accepts bytes from the CPU/bus side into a small FIFO and serialises them on TXD as 8N1 frames, LSB first. Bit timing comes from the shared baud generator: this block raises bps_en while a frame is in flight and advances one bit per clk_uart tick. It produces a per-frame completion interrupt for the UART peripheral wrapper.

Parameters:
DATA_W, 8, data bits per frame (fixed at 8 for this design; parameter for readability only)
FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2
CNT_W, 3, width of fifo_count = log2(FIFO_DEPTH)+1

Ports:
clk  in  1  system clock
RSTn  in  1  reset, asynchronous, active-low
clk_uart  in  1  baud tick from baud generator, one clk cycle wide, once per bit period while bps_en=1
wr_en  in  1  write strobe, one byte per asserted clk cycle
wr_data  in  8  byte to transmit
full  out  1  FIFO full; writes while full are dropped
overflow  out  1  sticky, set by a dropped write, cleared by ovf_clr
ovf_clr  in  1  clears overflow (ovf_clr wins over a same-cycle set)
fifo_count  out  CNT_W  entries currently held in FIFO (0..FIFO_DEPTH)
TXD  out  1  serial output, idle high
bps_en  out  1  baud generator enable, high for the whole frame
busy  out  1  high when FSM is not IDLE or FIFO is non-empty
interrupt  out  1  one clk pulse at the end of every stop bit

Behaviour:
- Reset (async, RSTn=0): TXD=1, bps_en=0, busy=0, interrupt=0, full=0, overflow=0, fifo_count=0, FSM=IDLE, FIFO emptied. A reset mid-frame aborts the frame; TXD returns high immediately.
- Baud contract: the baud generator clears its divider while bps_en=0, so the first clk_uart tick arrives one full bit period after bps_en rises. Ticks are ignored in IDLE.
- FSM states: IDLE, START, DATA, STOP; all registered.
- IDLE: TXD=1, bps_en=0. If FIFO is non-empty: pop head into shift_reg, bit_cnt=0, go to START next cycle. Latency from wr_en into an empty idle FIFO to TXD falling is 2 clk cycles.
- START: TXD=0, bps_en=1. On tick -> DATA.
- DATA: TXD=shift_reg[0]. On tick: shift right, bit_cnt+1. On the tick with bit_cnt=7 -> STOP.
- STOP: TXD=1. On tick: interrupt=1 for that cycle. If FIFO is non-empty, pop and go directly to START, keeping bps_en high (back-to-back frames with no idle gap). Otherwise go to IDLE with bps_en=0.
- TXD is driven from a register (no combinational glitches).
- FIFO: circular buffer with pointers one bit wider than the index; full and empty come from pointer compare; wrap-around is natural.
- Write while full: dropped, overflow set, FIFO contents unchanged.
- Write and pop in the same cycle: both take effect, fifo_count unchanged. Full is evaluated on the pre-cycle state, so a write while full is dropped even if a pop occurs in the same cycle.
- Write to an empty FIFO while IDLE: byte is written, popped on the next cycle.
- A tick coinciding with the FSM leaving IDLE is ignored; it cannot occur when the baud contract holds.

Decomposition:
- Shared package uart_pkg: FSM state encoding (ST_IDLE=0, ST_START=1, ST_DATA=2, ST_STOP=3), UART_DATA_W=8, stop/idle line level constant.
- Sub-module uart_tx_fifo_mem: synchronous FIFO (wr_en, wr_data, rd_en, rd_data, full, empty, count). It is reusable later as an RX buffer. The top contains the FSM, shift register and bit counter.

Test Plan:
Bench uses clk_uart = 1-cycle pulse every 16 clk while bps_en=1, divider cleared when bps_en=0.
- Single byte: write 0x55 at idle -> TXD falls 2 clk later; bit sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each 16 clk; interrupt pulses once after the stop bit; bps_en and busy return to 0.
- Back-to-back: write 0xA3, 0x0F in consecutive cycles -> two frames with no idle gap (start of the second frame directly follows the stop of the first, bps_en stays high); two interrupt pulses; RX-model decode yields 0xA3, 0x0F.
- Full/overflow: with TX busy, write 5 bytes 0x01..0x05 in 5 cycles -> full=1 after the 4th write with fifo_count=4; 0x05 is dropped and overflow=1; transmitted order is the in-flight byte, then 0x01..0x04. Pulse ovf_clr -> overflow=0.
- Simultaneous write and pop: FIFO count=1, write on the STOP->START pop cycle -> fifo_count stays 1; no byte is lost or duplicated.
- Reset mid-frame: assert RSTn=0 during DATA bit 3 of 0xFF -> TXD=1 and bps_en=0 immediately, fifo_count=0; after release, a fresh write of 0x81 transmits correctly.
- Wrap-around: stream 12 bytes 0x10..0x1B, keeping the FIFO partially filled -> all 12 frames are received in order and interrupt pulses exactly 12 times.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and TX FSM state encoding
package uart_pkg;

  localparam int   UART_DATA_W    = 8;
  localparam logic UART_LINE_IDLE = 1'b1;  // idle line and stop bit level

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - synchronous first-word-fall-through FIFO
// Pointers carry one extra wrap bit so full/empty/count fall out of a compare.
module uart_tx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              wr_fire;
  logic              rd_fire;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign count   = CNT_W'(wr_ptr_q - rd_ptr_q);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter, LSB first
// One bit per clk_uart tick; the stop-bit tick pops the next byte so frames run back to back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              clk_uart,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              TXD,
  output logic              bps_en,
  output logic              busy,
  output logic              interrupt
);

  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              txd_q;
  logic              bps_en_q;
  logic              irq_q;
  logic              ovf_q;
  logic              ovf_d;

  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;

  assign fifo_rd_en = (state_q == ST_IDLE) || ((state_q == ST_STOP) && clk_uart);

  uart_tx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .RSTn    (RSTn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A clear in the same cycle as a dropped write leaves the flag low.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && fifo_full) ovf_d = 1'b1;
    if (ovf_clr)            ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= UART_LINE_IDLE;
      bps_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          txd_q    <= UART_LINE_IDLE;
          bps_en_q <= 1'b0;
          if (!fifo_empty) begin
            shift_q   <= fifo_rd_data;
            bit_cnt_q <= '0;
            state_q   <= ST_START;
            txd_q     <= 1'b0;
            bps_en_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_uart) begin
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (clk_uart) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= ST_STOP;
              txd_q   <= UART_LINE_IDLE;
            end else begin
              txd_q <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (clk_uart) begin
            irq_q <= 1'b1;
            if (!fifo_empty) begin
              shift_q   <= fifo_rd_data;
              bit_cnt_q <= '0;
              state_q   <= ST_START;
              txd_q     <= 1'b0;
            end else begin
              state_q  <= ST_IDLE;
              bps_en_q <= 1'b0;
              txd_q    <= UART_LINE_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign full      = fifo_full;
  assign overflow  = ovf_q;
  assign TXD       = txd_q;
  assign bps_en    = bps_en_q;
  assign interrupt = irq_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk;
  logic       RSTn;
  logic       clk_uart;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic       ovf_clr;
  logic [2:0] fifo_count;
  logic       TXD;
  logic       bps_en;
  logic       busy;
  logic       interrupt;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_fifo dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .clk_uart   (clk_uart),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .fifo_count (fifo_count),
    .TXD        (TXD),
    .bps_en     (bps_en),
    .busy       (busy),
    .interrupt  (interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud generator: divider held clear while bps_en is low, tick every 16 clk.
  logic [3:0] div;
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn)        div <= 4'd0;
    else if (!bps_en) div <= 4'd0;
    else              div <= div + 4'd1;
  end
  assign clk_uart = bps_en && (div == 4'd15);

  // Receiver model: mid-bit sampling of TXD, plus interrupt counter.
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         rx_err = 0;
  int         irq_cnt = 0;

  always @(negedge clk) begin
    if (!RSTn) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (TXD === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 8) begin
        if (TXD !== 1'b0) begin
          rx_err++;
          rx_busy = 1'b0;
        end
      end else if (rx_cnt > 8 && rx_cnt < 152 && (rx_cnt % 16) == 8) begin
        rx_sh = {TXD, rx_sh[7:1]};
      end else if (rx_cnt == 152) begin
        if (TXD !== 1'b1) rx_err++;
        else              rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end
    end
    if (RSTn && interrupt === 1'b1) irq_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || rx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_drain: busy=%b after %0d cycles, want 0", name, busy, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    n_cmp++; if (TXD !== 1'b1)      begin n_bad++; $display("FAIL reset_txd: got %b want 1", TXD); end
    n_cmp++; if (bps_en !== 1'b0)   begin n_bad++; $display("FAIL reset_bps_en: got %b want 0", bps_en); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", interrupt); end
    n_cmp++; if (full !== 1'b0)     begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_single;
    logic [9:0] exp_bits;
    int         base;
    exp_bits = 10'b1_0101_0101_0;  // stop, data 0x55 MSB..LSB, start
    base = irq_cnt;
    rx_q.delete();
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h55;
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (TXD !== 1'b1) begin n_bad++; $display("FAIL single_lat1_txd: got %b want 1", TXD); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_lat1_count: got %0d want 1", fifo_count); end
    @(negedge clk);
    n_cmp++; if (TXD !== 1'b0) begin n_bad++; $display("FAIL single_lat2_txd: got %b want 0", TXD); end
    n_cmp++; if (bps_en !== 1'b1) begin n_bad++; $display("FAIL single_bps_en: got %b want 1", bps_en); end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (TXD !== exp_bits[i]) begin
        n_bad++; $display("FAIL single_bit%0d: got %b want %b", i, TXD, exp_bits[i]);
      end
      repeat (16) @(negedge clk);
    end
    wait_drain("single", 100);
    n_cmp++; if (irq_cnt - base != 1) begin n_bad++; $display("FAIL single_irq: got %0d pulses want 1", irq_cnt - base); end
    n_cmp++; if (bps_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: bps_en=%b busy=%b want 0 0", bps_en, busy); end
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin n_bad++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[2];
    int base;
    int n;
    exp = '{8'hA3, 8'h0F};
    base = irq_cnt;
    rx_q.delete();
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'hA3;
    @(posedge clk); #1; wr_data = 8'h0F;
    @(posedge clk); #1; wr_en = 1'b0;
    n = 0;
    @(negedge clk);
    while (bps_en === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n != 320) begin n_bad++; $display("FAIL b2b_bps_high: got %0d cycles want 320", n); end
    wait_drain("b2b", 100);
    n_cmp++; if (irq_cnt - base != 2) begin n_bad++; $display("FAIL b2b_irq: got %0d pulses want 2", irq_cnt - base); end
    n_cmp++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL b2b_rx_len: got %0d want 2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp[i]) begin n_bad++; $display("FAIL b2b_rx%0d: got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] exp[5];
    int base;
    exp = '{8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
    base = irq_cnt;
    rx_q.delete();
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h99;
    @(posedge clk); #1; wr_en = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'(i);
      if (i == 5) begin
        @(negedge clk);
        n_cmp++; if (full !== 1'b1 || fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_full4: full=%b count=%0d want 1 4", full, fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1 || fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_set: ovf=%b count=%0d want 1 4", overflow, fifo_count); end
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h66; ovf_clr = 1'b1;
    @(posedge clk); #1; wr_en = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_wins: got %b want 0", overflow); end
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h77;
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_reset2: got %b want 1", overflow); end
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    wait_drain("ovf", 1100);
    n_cmp++; if (irq_cnt - base != 5) begin n_bad++; $display("FAIL ovf_irq: got %0d pulses want 5", irq_cnt - base); end
    n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL ovf_rx_len: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp[i]) begin n_bad++; $display("FAIL ovf_rx%0d: got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_simul_wr_pop;
    logic [7:0] exp[3];
    int base;
    int ticks;
    int n;
    exp = '{8'h3C, 8'hC3, 8'h5A};
    base = irq_cnt;
    rx_q.delete();
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h3C;
    @(posedge clk); #1; wr_en = 1'b0;
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'hC3;
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL simul_pre_count: got %0d want 1", fifo_count); end
    ticks = 0;
    n = 0;
    while (ticks < 10 && n < 300) begin
      @(negedge clk);
      n++;
      if (clk_uart === 1'b1) ticks++;
    end
    n_cmp++; if (ticks != 10) begin n_bad++; $display("FAIL simul_ticks: got %0d want 10", ticks); end
    wr_en = 1'b1; wr_data = 8'h5A;
    @(posedge clk); #1; wr_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL simul_count: got %0d want 1", fifo_count); end
    n_cmp++; if (TXD !== 1'b0 || bps_en !== 1'b1) begin n_bad++; $display("FAIL simul_restart: txd=%b bps_en=%b want 0 1", TXD, bps_en); end
    wait_drain("simul", 600);
    n_cmp++; if (irq_cnt - base != 3) begin n_bad++; $display("FAIL simul_irq: got %0d pulses want 3", irq_cnt - base); end
    n_cmp++; if (rx_q.size() != 3) begin n_bad++; $display("FAIL simul_rx_len: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp[i]) begin n_bad++; $display("FAIL simul_rx%0d: got %h want %h", i, rx_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset_midframe;
    int base;
    rx_q.delete();
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'hFF;
    @(posedge clk); #1; wr_data = 8'hEE;
    @(posedge clk); #1; wr_en = 1'b0;
    repeat (72) @(negedge clk);
    n_cmp++; if (bps_en !== 1'b1 || fifo_count !== 3'd1) begin n_bad++; $display("FAIL rstmid_pre: bps_en=%b count=%0d want 1 1", bps_en, fifo_count); end
    RSTn = 1'b0;
    #1;
    n_cmp++; if (TXD !== 1'b1)   begin n_bad++; $display("FAIL rstmid_txd: got %b want 1", TXD); end
    n_cmp++; if (bps_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_bps_en: got %b want 0", bps_en); end
    n_cmp++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_fifo: count=%0d busy=%b want 0 0", fifo_count, busy); end
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    repeat (2) @(negedge clk);
    base = irq_cnt;
    @(posedge clk); #1; wr_en = 1'b1; wr_data = 8'h81;
    @(posedge clk); #1; wr_en = 1'b0;
    wait_drain("rstmid", 300);
    n_cmp++; if (irq_cnt - base != 1) begin n_bad++; $display("FAIL rstmid_irq: got %0d pulses want 1", irq_cnt - base); end
    n_cmp++; if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin n_bad++; $display("FAIL rstmid_rx: got %0d bytes first %h want 1 byte 81", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_wrap;
    int base;
    int sent;
    int n;
    base = irq_cnt;
    rx_q.delete();
    sent = 0;
    n = 0;
    while (sent < 12 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (fifo_count < 3'd2) begin
        wr_en = 1'b1; wr_data = 8'h10 + 8'(sent);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(posedge clk); #1; wr_en = 1'b0;
    n_cmp++; if (sent != 12) begin n_bad++; $display("FAIL wrap_sent: got %0d want 12", sent); end
    wait_drain("wrap", 2500);
    n_cmp++; if (irq_cnt - base != 12) begin n_bad++; $display("FAIL wrap_irq: got %0d pulses want 12", irq_cnt - base); end
    n_cmp++; if (rx_q.size() != 12) begin n_bad++; $display("FAIL wrap_rx_len: got %0d want 12", rx_q.size()); end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL wrap_rx%0d: got %h want %h", i, rx_q[i], 8'h10 + 8'(i)); end
    end
  endtask

  initial begin
    RSTn    = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    RSTn = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_simul_wr_pop;
    test_reset_midframe;
    test_wrap;
    n_cmp++; if (rx_err != 0) begin n_bad++; $display("FAIL rx_framing: got %0d framing errors want 0", rx_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
